// File: rtl/sparc_exu_ccr_pipe.sv
// -----------------------------------------------------------------------------
// sparc_exu_ccr_pipe
//
// Condition-code stage that sits behind the integer ALU. It turns the ALU's
// E-stage flag bits into SPARC icc/xcc, carries them through M and W, and
// commits them into a per-thread CCR array at the end of W. WRCCR commits
// go into the same array. An E-stage consumer of any thread reads a bypassed
// CCR value.
//
// Ports
//   rclk, reset            clock (rising edge), async active-high reset
//   alu_*_e                ALU flag sources for the instruction in E
//   ecl_rs1_{63,31}_e      rs1 sign bits, used for overflow
//   ecl_setcc_e            E instruction writes the CCR
//   ecl_sel_add_e          1: adder flags, 0: logic flags
//   ecl_sub_e              subtract: carry becomes borrow
//   ecl_tid_e              thread of the E instruction
//   ecl_kill_m             kill the instruction in M
//   ecl_wrccr_{w,data_w,tid_w}  WRCCR commit at W
//   ecl_rd_tid_e           thread whose CCR is read this cycle
//   ccr_cc_e               flags formed this cycle (combinational)
//   ccr_byp_cc_e           bypassed CCR for ecl_rd_tid_e (combinational)
//   ccr_commit_w           registered pulse: the array was written last edge
// -----------------------------------------------------------------------------
module sparc_exu_ccr_pipe #(
    parameter int NTHR = 4,
    parameter int CCW  = 8
) (
    input  logic                    rclk,
    input  logic                    reset,
    input  logic                    alu_add_n64_e,
    input  logic                    alu_add_n32_e,
    input  logic                    alu_log_n64_e,
    input  logic                    alu_log_n32_e,
    input  logic                    alu_zhigh_e,
    input  logic                    alu_zlow_e,
    input  logic                    alu_cout32_e,
    input  logic                    alu_cout64_e_l,
    input  logic                    alu_adderin2_63_e,
    input  logic                    alu_adderin2_31_e,
    input  logic                    ecl_rs1_63_e,
    input  logic                    ecl_rs1_31_e,
    input  logic                    ecl_setcc_e,
    input  logic                    ecl_sel_add_e,
    input  logic                    ecl_sub_e,
    input  logic [$clog2(NTHR)-1:0] ecl_tid_e,
    input  logic                    ecl_kill_m,
    input  logic                    ecl_wrccr_w,
    input  logic [CCW-1:0]          ecl_wrccr_data_w,
    input  logic [$clog2(NTHR)-1:0] ecl_wrccr_tid_w,
    input  logic [$clog2(NTHR)-1:0] ecl_rd_tid_e,
    output logic [CCW-1:0]          ccr_cc_e,
    output logic [CCW-1:0]          ccr_byp_cc_e,
    output logic                    ccr_commit_w
);

    localparam int TIDW = $clog2(NTHR);

    // ---------------------------------------------------------------- E stage
    // Overflow: operands (second one as seen by the adder, i.e. already
    // inverted for subtract) agree in sign and the result sign differs.
    logic v32_e, v64_e, c32_e, c64_e;
    logic [3:0] icc_e, xcc_e;

    assign v32_e = (ecl_rs1_31_e == alu_adderin2_31_e) & (alu_add_n32_e != ecl_rs1_31_e);
    assign v64_e = (ecl_rs1_63_e == alu_adderin2_63_e) & (alu_add_n64_e != ecl_rs1_63_e);
    // SPARC reports borrow on subtract, which is the inverted adder carry.
    assign c32_e = alu_cout32_e ^ ecl_sub_e;
    assign c64_e = ~alu_cout64_e_l ^ ecl_sub_e;

    // NOTE: every signal assigned in an always_comb gets a value on every
    // path (here via the if/else), otherwise a latch is inferred.
    always_comb begin
        if (ecl_sel_add_e) begin
            icc_e = {alu_add_n32_e, alu_zlow_e, v32_e, c32_e};
            xcc_e = {alu_add_n64_e, alu_zlow_e & alu_zhigh_e, v64_e, c64_e};
        end else begin
            icc_e = {alu_log_n32_e, alu_zlow_e, 2'b00};
            xcc_e = {alu_log_n64_e, alu_zlow_e & alu_zhigh_e, 2'b00};
        end
    end

    assign ccr_cc_e = {xcc_e, icc_e};

    // ------------------------------------------------------ pipeline / array
    logic            vld_m_q, vld_w_q, vld_w_d;
    logic [CCW-1:0]  cc_m_q, cc_w_q;
    logic [TIDW-1:0] tid_m_q, tid_w_q;
    logic [CCW-1:0]  ccr_q [NTHR];
    logic [CCW-1:0]  ccr_d [NTHR];
    logic            commit_q, commit_d;

    // A killed M entry is dropped here; kill without a valid has no effect.
    assign vld_w_d  = vld_m_q & ~ecl_kill_m;
    assign commit_d = vld_w_q | ecl_wrccr_w;

    always_comb begin
        ccr_d = ccr_q;
        if (vld_w_q) begin
            ccr_d[tid_w_q] = cc_w_q;
        end
        // Applied second so WRCCR wins a same-thread collision.
        if (ecl_wrccr_w) begin
            ccr_d[ecl_wrccr_tid_w] = ecl_wrccr_data_w;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values of its sources regardless of statement order.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            vld_m_q  <= 1'b0;
            vld_w_q  <= 1'b0;
            cc_m_q   <= '0;
            cc_w_q   <= '0;
            tid_m_q  <= '0;
            tid_w_q  <= '0;
            commit_q <= 1'b0;
            // NOTE: the CCR array is architected state read straight after
            // reset, so unlike a RAM every entry is cleared here.
            for (int i = 0; i < NTHR; i++) begin
                ccr_q[i] <= '0;
            end
        end else begin
            vld_m_q  <= ecl_setcc_e;
            cc_m_q   <= ccr_cc_e;
            tid_m_q  <= ecl_tid_e;
            vld_w_q  <= vld_w_d;
            cc_w_q   <= cc_m_q;
            tid_w_q  <= tid_m_q;
            commit_q <= commit_d;
            ccr_q    <= ccr_d;
        end
    end

    assign ccr_commit_w = commit_q;

    // ----------------------------------------------------------------- bypass
    // Youngest producer first: M, then the WRCCR landing this cycle, then W,
    // then the array. Reset forces zero because the WRCCR path is purely
    // combinational from inputs.
    always_comb begin
        ccr_byp_cc_e = ccr_q[ecl_rd_tid_e];
        if (reset) begin
            ccr_byp_cc_e = '0;
        end else if (vld_m_q & ~ecl_kill_m & (tid_m_q == ecl_rd_tid_e)) begin
            ccr_byp_cc_e = cc_m_q;
        end else if (ecl_wrccr_w & (ecl_wrccr_tid_w == ecl_rd_tid_e)) begin
            ccr_byp_cc_e = ecl_wrccr_data_w;
        end else if (vld_w_q & (tid_w_q == ecl_rd_tid_e)) begin
            ccr_byp_cc_e = cc_w_q;
        end
    end

endmodule

// File: tb/tb_sparc_exu_ccr_pipe.sv
// -----------------------------------------------------------------------------
// tb_sparc_exu_ccr_pipe
//
// Drives ALU operands, derives the ALU flag pins from 64-bit arithmetic, and
// predicts condition codes from signed/unsigned arithmetic. The pipeline is
// modelled as a per-cycle issue history: an instruction issued in cycle c is
// visible from M in c+1, from W in c+2, and lands in the CCR array at the
// end of c+2 unless killed in c+1.
// -----------------------------------------------------------------------------
module tb_sparc_exu_ccr_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_add_n64_e, alu_add_n32_e, alu_log_n64_e, alu_log_n32_e;
    logic       alu_zhigh_e, alu_zlow_e, alu_cout32_e, alu_cout64_e_l;
    logic       alu_adderin2_63_e, alu_adderin2_31_e, ecl_rs1_63_e, ecl_rs1_31_e;
    logic       ecl_setcc_e, ecl_sel_add_e, ecl_sub_e, ecl_kill_m, ecl_wrccr_w;
    logic [1:0] ecl_tid_e, ecl_wrccr_tid_w, ecl_rd_tid_e;
    logic [7:0] ecl_wrccr_data_w;
    logic [7:0] ccr_cc_e, ccr_byp_cc_e;
    logic       ccr_commit_w;

    always #5 clk = ~clk;

    sparc_exu_ccr_pipe dut (
        .rclk              (clk),
        .reset             (reset),
        .alu_add_n64_e     (alu_add_n64_e),
        .alu_add_n32_e     (alu_add_n32_e),
        .alu_log_n64_e     (alu_log_n64_e),
        .alu_log_n32_e     (alu_log_n32_e),
        .alu_zhigh_e       (alu_zhigh_e),
        .alu_zlow_e        (alu_zlow_e),
        .alu_cout32_e      (alu_cout32_e),
        .alu_cout64_e_l    (alu_cout64_e_l),
        .alu_adderin2_63_e (alu_adderin2_63_e),
        .alu_adderin2_31_e (alu_adderin2_31_e),
        .ecl_rs1_63_e      (ecl_rs1_63_e),
        .ecl_rs1_31_e      (ecl_rs1_31_e),
        .ecl_setcc_e       (ecl_setcc_e),
        .ecl_sel_add_e     (ecl_sel_add_e),
        .ecl_sub_e         (ecl_sub_e),
        .ecl_tid_e         (ecl_tid_e),
        .ecl_kill_m        (ecl_kill_m),
        .ecl_wrccr_w       (ecl_wrccr_w),
        .ecl_wrccr_data_w  (ecl_wrccr_data_w),
        .ecl_wrccr_tid_w   (ecl_wrccr_tid_w),
        .ecl_rd_tid_e      (ecl_rd_tid_e),
        .ccr_cc_e          (ccr_cc_e),
        .ccr_byp_cc_e      (ccr_byp_cc_e),
        .ccr_commit_w      (ccr_commit_w)
    );

    // ------------------------------------------------------------- bookkeeping
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    localparam int HMAX = 4096;
    bit         h_set  [HMAX];
    logic [1:0] h_tid  [HMAX];
    logic [7:0] h_cc   [HMAX];
    bit         h_kill [HMAX];
    logic [7:0] ccr_m  [4];
    logic       exp_commit = 1'b0;
    logic [7:0] exp_cc_e   = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Condition codes from the arithmetic definition of each flag.
    function automatic logic [7:0] cc_model(input bit is_add, input bit sub,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic [64:0] t64;
        logic [32:0] t32;
        logic        v32, v64, c32, c64;
        if (!is_add) begin
            r = a ^ b;
            return {r[63], r == 64'd0, 2'b00, r[31], r[31:0] == 32'd0, 2'b00};
        end
        r = sub ? a - b : a + b;
        if (sub) begin
            v64 = (a[63] != b[63]) && (r[63] != a[63]);
            v32 = (a[31] != b[31]) && (r[31] != a[31]);
            c64 = a < b;
            c32 = a[31:0] < b[31:0];
        end else begin
            t64 = {1'b0, a} + {1'b0, b};
            t32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
            v64 = (a[63] == b[63]) && (r[63] != a[63]);
            v32 = (a[31] == b[31]) && (r[31] != a[31]);
            c64 = t64[64];
            c32 = t32[32];
        end
        return {r[63], r == 64'd0, v64, c64, r[31], r[31:0] == 32'd0, v32, c32};
    endfunction

    // Drive the ALU pins as a real adder / logic unit would for a op b.
    task automatic set_op(input bit is_add, input bit sub, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] in2, res, lres;
        logic [64:0] s65;
        logic [32:0] s33;
        in2 = sub ? ~b : b;
        s65 = {1'b0, a} + {1'b0, in2} + 65'(sub);
        s33 = {1'b0, a[31:0]} + {1'b0, in2[31:0]} + 33'(sub);
        lres = a ^ b;
        res  = is_add ? s65[63:0] : lres;
        alu_add_n64_e     = s65[63];
        alu_add_n32_e     = s65[31];
        alu_log_n64_e     = lres[63];
        alu_log_n32_e     = lres[31];
        alu_zhigh_e       = (res[63:32] == 32'd0);
        alu_zlow_e        = (res[31:0] == 32'd0);
        alu_cout32_e      = s33[32];
        alu_cout64_e_l    = ~s65[64];
        alu_adderin2_63_e = in2[63];
        alu_adderin2_31_e = in2[31];
        ecl_rs1_63_e      = a[63];
        ecl_rs1_31_e      = a[31];
        ecl_sel_add_e     = is_add;
        ecl_sub_e         = sub;
        exp_cc_e          = cc_model(is_add, sub, a, b);
    endtask

    task automatic idle();
        ecl_setcc_e = 1'b0;
        ecl_kill_m  = 1'b0;
        ecl_wrccr_w = 1'b0;
    endtask

    // Expected bypass value: youngest visible producer for rd_tid wins.
    function automatic logic [7:0] exp_byp();
        if (reset)
            return 8'h00;
        if (cyc >= 1 && h_set[cyc-1] && !h_kill[cyc] && h_tid[cyc-1] == ecl_rd_tid_e)
            return h_cc[cyc-1];
        if (ecl_wrccr_w && ecl_wrccr_tid_w == ecl_rd_tid_e)
            return ecl_wrccr_data_w;
        if (cyc >= 2 && h_set[cyc-2] && !h_kill[cyc-1] && h_tid[cyc-2] == ecl_rd_tid_e)
            return h_cc[cyc-2];
        return ccr_m[ecl_rd_tid_e];
    endfunction

    task automatic model_edge();
        logic nc;
        if (reset) begin
            for (int c = 0; c <= cyc; c++) h_set[c] = 1'b0;
            for (int i = 0; i < 4; i++) ccr_m[i] = 8'h00;
            exp_commit = 1'b0;
        end else begin
            nc = 1'b0;
            if (cyc >= 2 && h_set[cyc-2] && !h_kill[cyc-1]) begin
                ccr_m[h_tid[cyc-2]] = h_cc[cyc-2];
                nc = 1'b1;
            end
            if (ecl_wrccr_w) begin
                ccr_m[ecl_wrccr_tid_w] = ecl_wrccr_data_w;
                nc = 1'b1;
            end
            exp_commit = nc;
        end
    endtask

    // One cycle: inputs are already driven (after a falling edge); check,
    // take the rising edge, update the model, return at the next falling edge.
    task automatic step(input bit kchk = 1'b0, input logic [7:0] kval = 8'h00, input string ktag = "");
        #1;
        h_set[cyc]  = ecl_setcc_e & ~reset;
        h_tid[cyc]  = ecl_tid_e;
        h_cc[cyc]   = exp_cc_e;
        h_kill[cyc] = ecl_kill_m;
        check("cc_e", ccr_cc_e, exp_cc_e);
        check("byp", ccr_byp_cc_e, exp_byp());
        check("commit", {7'd0, ccr_commit_w}, {7'd0, reset ? 1'b0 : exp_commit});
        if (kchk) check(ktag, ccr_byp_cc_e, kval);
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ccr_m[i] = 8'h00;
        reset = 1'b1;
        idle();
        ecl_tid_e = 2'd0; ecl_rd_tid_e = 2'd0;
        ecl_wrccr_tid_w = 2'd0; ecl_wrccr_data_w = 8'h00;
        set_op(1'b1, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        #1 check("reset_commit", {7'd0, ccr_commit_w}, 8'h00);
        check("reset_byp", ccr_byp_cc_e, 8'h00);
        step();
        step();
        reset = 1'b0;

        // add 0x7FFFFFFF + 1, thread 0
        set_op(1'b1, 1'b0, 64'h0000_0000_7FFF_FFFF, 64'd1);
        ecl_setcc_e = 1'b1; ecl_tid_e = 2'd0; ecl_rd_tid_e = 2'd0;
        #1 check("add_cc_e", ccr_cc_e, 8'h0A);
        step();
        idle();
        step(1'b1, 8'h0A, "add_byp_m");
        step(1'b1, 8'h0A, "add_byp_w");
        step(1'b1, 8'h0A, "add_ccr0");

        // sub 0 - 1, thread 1
        set_op(1'b1, 1'b1, 64'd0, 64'd1);
        ecl_setcc_e = 1'b1; ecl_tid_e = 2'd1; ecl_rd_tid_e = 2'd1;
        #1 check("sub_cc_e", ccr_cc_e, 8'h99);
        step();
        idle();
        step();
        step();
        step(1'b1, 8'h99, "sub_ccr1");

        // back-to-back setcc on thread 2: 0x44 then 0x11
        ecl_rd_tid_e = 2'd2;
        set_op(1'b0, 1'b0, 64'h5, 64'h5);
        ecl_setcc_e = 1'b1; ecl_tid_e = 2'd2;
        step();
        set_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        step(1'b1, 8'h44, "chain_t1");
        idle();
        step(1'b1, 8'h11, "chain_t2");
        step(1'b1, 8'h11, "chain_t3");
        step(1'b1, 8'h11, "chain_arr");

        // killed setcc on thread 1 must never show
        ecl_rd_tid_e = 2'd1;
        set_op(1'b0, 1'b0, 64'h5, 64'h5);
        ecl_setcc_e = 1'b1; ecl_tid_e = 2'd1;
        step(1'b1, 8'h99, "kill_e");
        idle();
        ecl_kill_m = 1'b1;
        step(1'b1, 8'h99, "kill_m");
        ecl_kill_m = 1'b0;
        step(1'b1, 8'h99, "kill_w");
        #1 check("kill_commit", {7'd0, ccr_commit_w}, 8'h00);
        step(1'b1, 8'h99, "kill_arr");

        // W commit of 0x05 on thread 3 colliding with WRCCR to thread 3
        ecl_rd_tid_e = 2'd3;
        set_op(1'b1, 1'b0, 64'h0000_0001_FFFF_FFFF, 64'd1);
        ecl_setcc_e = 1'b1; ecl_tid_e = 2'd3;
        #1 check("coll_cc_e", ccr_cc_e, 8'h05);
        step();
        idle();
        step();
        ecl_wrccr_w = 1'b1; ecl_wrccr_tid_w = 2'd3; ecl_wrccr_data_w = 8'hA0;
        step();
        ecl_wrccr_w = 1'b0;
        step(1'b1, 8'hA0, "coll_same");

        // same, but WRCCR to thread 0: both land
        ecl_setcc_e = 1'b1; ecl_tid_e = 2'd3;
        step();
        idle();
        step();
        ecl_wrccr_w = 1'b1; ecl_wrccr_tid_w = 2'd0; ecl_wrccr_data_w = 8'hA0;
        step();
        ecl_wrccr_w = 1'b0;
        step(1'b1, 8'h05, "coll_diff3");
        ecl_rd_tid_e = 2'd0;
        step(1'b1, 8'hA0, "coll_diff0");

        // async reset with both M and W valid
        set_op(1'b1, 1'b1, 64'd0, 64'd1);
        ecl_setcc_e = 1'b1; ecl_tid_e = 2'd0;
        step();
        set_op(1'b1, 1'b0, 64'h0000_0000_7FFF_FFFF, 64'd1);
        ecl_tid_e = 2'd1;
        step();
        idle();
        #2 reset = 1'b1;
        #1 check("rst_async_byp", ccr_byp_cc_e, 8'h00);
        check("rst_async_commit", {7'd0, ccr_commit_w}, 8'h00);
        step();
        step();
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            ecl_rd_tid_e = 2'(t);
            step(1'b1, 8'h00, "rst_ccr");
        end

        // randomized traffic
        for (int n = 0; n < 700; n++) begin
            logic [63:0] a, b;
            int kind;
            kind = $urandom_range(0, 5);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (kind == 0) b = a;
            if (kind == 1) a = {32'd0, a[31:0]};
            set_op((kind != 2 && kind != 3), 1'($urandom), a, b);
            ecl_setcc_e      = ($urandom_range(0, 1) == 1);
            ecl_tid_e        = 2'($urandom_range(0, 3));
            ecl_kill_m       = ($urandom_range(0, 4) == 0);
            ecl_wrccr_w      = ($urandom_range(0, 6) == 0);
            ecl_wrccr_tid_w  = 2'($urandom_range(0, 3));
            ecl_wrccr_data_w = 8'($urandom);
            ecl_rd_tid_e     = 2'($urandom_range(0, 3));
            reset            = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
